// File: rtl/timer_input_ctrl.sv
// Microwave timer input sequencer: BCD entry buffer, load handshake, display mux select.
// Optional TIMER_INPUT_QUICKSTART_EN: start in IDLE loads a 30 s quick-start value.
module timer_input_ctrl #(
  parameter int DIGITS = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         key_valid,
  input  logic [3:0]                   key_code,
  input  logic                         clear,
  input  logic                         start,
  input  logic                         load_ack,
  input  logic                         timer_done,
  output logic [4*DIGITS-1:0]          entry_value,
  output logic [$clog2(DIGITS+1)-1:0]  digit_count,
  output logic                         load_req,
  output logic [4*DIGITS-1:0]          load_value,
  output logic                         mux_sel,
  output logic                         timer_cancel,
  output logic                         err
);

  localparam int W  = 4 * DIGITS;
  localparam int CW = $clog2(DIGITS + 1);
  localparam logic [CW-1:0] FULL = CW'(DIGITS);
  localparam logic [CW-1:0] ONE  = CW'(1);

  typedef enum logic [1:0] {
    IDLE,
    ENTRY,
    LOAD,
    RUN
  } state_t;

  state_t          state;
  state_t          state_nx;
  logic [W-1:0]    entry_nx;
  logic [CW-1:0]   count_nx;
  logic            req_nx;
  logic [W-1:0]    lval_nx;
  logic            mux_nx;
  logic            cancel_nx;
  logic            err_nx;

  logic            key_ok;
  logic            buf_zero;
  logic            tens_bad;
  logic [W-1:0]    shifted;

  assign key_ok   = key_valid && (key_code <= 4'd9);
  assign buf_zero = (entry_value == '0);
  assign tens_bad = (entry_value[7:4] > 4'd5);
  assign shifted  = {entry_value[W-5:0], key_code};

  always_comb begin
    state_nx  = state;
    entry_nx  = entry_value;
    count_nx  = digit_count;
    req_nx    = load_req;
    lval_nx   = load_value;
    mux_nx    = mux_sel;
    cancel_nx = 1'b0;
    err_nx    = 1'b0;
    unique case (state)
      IDLE: begin
        if (clear) begin
          entry_nx = '0;
          count_nx = '0;
        end
`ifdef TIMER_INPUT_QUICKSTART_EN
        else if (start) begin
          lval_nx  = W'(8'h30);
          req_nx   = 1'b1;
          state_nx = LOAD;
        end
`endif
        else if (key_ok) begin
          entry_nx = shifted;
          count_nx = ONE;
          state_nx = ENTRY;
        end
      end
      ENTRY: begin
        if (clear) begin
          entry_nx = '0;
          count_nx = '0;
          state_nx = IDLE;
        end else if (start) begin
          if (buf_zero || tens_bad) begin
            err_nx = 1'b1;
          end else begin
            lval_nx  = entry_value;
            req_nx   = 1'b1;
            state_nx = LOAD;
          end
        end else if (key_ok && (digit_count != FULL)) begin
          entry_nx = shifted;
          count_nx = digit_count + ONE;
        end
      end
      LOAD: begin
        // ack beats a same-cycle clear; the clear is simply discarded
        if (load_ack && load_req) begin
          req_nx   = 1'b0;
          entry_nx = '0;
          count_nx = '0;
          mux_nx   = 1'b1;
          state_nx = RUN;
        end else if (clear) begin
          req_nx   = 1'b0;
          state_nx = ENTRY;
        end
      end
      RUN: begin
        if (clear) begin
          cancel_nx = 1'b1;
          mux_nx    = 1'b0;
          state_nx  = IDLE;
        end else if (timer_done) begin
          mux_nx   = 1'b0;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      entry_value  <= '0;
      digit_count  <= '0;
      load_req     <= 1'b0;
      load_value   <= '0;
      mux_sel      <= 1'b0;
      timer_cancel <= 1'b0;
      err          <= 1'b0;
    end else begin
      state        <= state_nx;
      entry_value  <= entry_nx;
      digit_count  <= count_nx;
      load_req     <= req_nx;
      load_value   <= lval_nx;
      mux_sel      <= mux_nx;
      timer_cancel <= cancel_nx;
      err          <= err_nx;
    end
  end

endmodule

// File: tb/tb_timer_input_ctrl.sv
// Bench for timer_input_ctrl: directed vector table plus random run
// against a digit-queue reference model.
module tb_timer_input_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        key_valid = 1'b0;
  logic [3:0]  key_code = 4'd0;
  logic        clear = 1'b0;
  logic        start = 1'b0;
  logic        load_ack = 1'b0;
  logic        timer_done = 1'b0;
  logic [15:0] entry_value;
  logic [2:0]  digit_count;
  logic        load_req;
  logic [15:0] load_value;
  logic        mux_sel;
  logic        timer_cancel;
  logic        err;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  timer_input_ctrl #(.DIGITS(4)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .key_valid(key_valid),
    .key_code(key_code),
    .clear(clear),
    .start(start),
    .load_ack(load_ack),
    .timer_done(timer_done),
    .entry_value(entry_value),
    .digit_count(digit_count),
    .load_req(load_req),
    .load_value(load_value),
    .mux_sel(mux_sel),
    .timer_cancel(timer_cancel),
    .err(err)
  );

  typedef struct {
    logic        kv;
    logic [3:0]  kc;
    logic        clr;
    logic        st;
    logic        ack;
    logic        done;
    logic [15:0] ev;
    logic [2:0]  ec;
    logic        req;
    logic [15:0] lv;
    logic        mux;
    logic        er;
    logic        can;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(logic kv, logic [3:0] kc, logic clr, logic st,
                              logic ack, logic done, logic [15:0] ev,
                              logic [2:0] ec, logic req, logic [15:0] lv,
                              logic mux, logic er, logic can);
    vec_t v;
    v.kv = kv; v.kc = kc; v.clr = clr; v.st = st; v.ack = ack; v.done = done;
    v.ev = ev; v.ec = ec; v.req = req; v.lv = lv;
    v.mux = mux; v.er = er; v.can = can;
    tbl.push_back(v);
  endfunction

  function automatic logic [38:0] obs();
    return {entry_value, digit_count, load_req, load_value,
            mux_sel, err, timer_cancel};
  endfunction

  task automatic chk(string name, logic [38:0] act, logic [38:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h want=%h (ev,cnt,req,lv,mux,err,can)",
               name, act, exp);
    end
  endtask

  task automatic drive(logic kv, logic [3:0] kc, logic clr, logic st,
                       logic ack, logic done);
    key_valid = kv; key_code = kc; clear = clr;
    start = st; load_ack = ack; timer_done = done;
    @(posedge clk);
    #1;
  endtask

  // Reference model: mode 0 idle, 1 entry, 2 load, 3 run
  int          m_mode;
  int          m_digs[$];
  logic        m_req;
  logic [15:0] m_lv;
  logic        m_mux;
  logic        m_err;
  logic        m_can;

  function automatic logic [15:0] m_pack();
    int v = 0;
    foreach (m_digs[i]) v = v * 16 + m_digs[i];
    return v[15:0];
  endfunction

  function automatic void m_reset();
    m_mode = 0; m_digs.delete(); m_req = 0; m_lv = 0;
    m_mux = 0; m_err = 0; m_can = 0;
  endfunction

  function automatic void m_step(logic kv, logic [3:0] kc, logic clr,
                                 logic st, logic ack, logic done);
    bit good_key = kv && (kc < 10);
    int tens;
    m_err = 0;
    m_can = 0;
    case (m_mode)
      0: if (!clr && good_key) begin
        m_digs.push_back(int'(kc));
        m_mode = 1;
      end
      1: begin
        if (clr) begin
          m_digs.delete();
          m_mode = 0;
        end else if (st) begin
          tens = (m_digs.size() >= 2) ? m_digs[m_digs.size()-2] : 0;
          if (m_pack() == 0 || tens > 5) m_err = 1;
          else begin
            m_lv = m_pack(); m_req = 1; m_mode = 2;
          end
        end else if (good_key && m_digs.size() < 4) begin
          m_digs.push_back(int'(kc));
        end
      end
      2: begin
        if (ack) begin
          m_req = 0; m_digs.delete(); m_mux = 1; m_mode = 3;
        end else if (clr) begin
          m_req = 0; m_mode = 1;
        end
      end
      default: begin
        if (clr) begin
          m_can = 1; m_mux = 0; m_mode = 0;
        end else if (done) begin
          m_mux = 0; m_mode = 0;
        end
      end
    endcase
  endfunction

  function automatic logic [38:0] m_obs();
    logic [2:0] c = 3'(m_digs.size());
    return {m_pack(), c, m_req, m_lv, m_mux, m_err, m_can};
  endfunction

  task automatic mdrive(string name, logic kv, logic [3:0] kc, logic clr,
                        logic st, logic ack, logic done);
    m_step(kv, kc, clr, st, ack, done);
    drive(kv, kc, clr, st, ack, done);
    chk(name, obs(), m_obs());
  endtask

  initial begin
    // entry, load, completion
    add(1,1,0,0,0,0, 16'h0001,1,0,16'h0000,0,0,0);
    add(1,2,0,0,0,0, 16'h0012,2,0,16'h0000,0,0,0);
    add(1,3,0,0,0,0, 16'h0123,3,0,16'h0000,0,0,0);
    add(1,0,0,0,0,0, 16'h1230,4,0,16'h0000,0,0,0);
    add(0,0,0,1,0,0, 16'h1230,4,1,16'h1230,0,0,0);
    add(0,0,0,0,0,0, 16'h1230,4,1,16'h1230,0,0,0);
    add(0,0,0,0,1,0, 16'h0000,0,0,16'h1230,1,0,0);
    add(0,0,0,0,0,1, 16'h0000,0,0,16'h1230,0,0,0);
    // saturation, invalid code dropped
    add(1,9,0,0,0,0, 16'h0009,1,0,16'h1230,0,0,0);
    add(1,10,0,0,0,0,16'h0009,1,0,16'h1230,0,0,0);
    add(1,8,0,0,0,0, 16'h0098,2,0,16'h1230,0,0,0);
    add(1,7,0,0,0,0, 16'h0987,3,0,16'h1230,0,0,0);
    add(1,6,0,0,0,0, 16'h9876,4,0,16'h1230,0,0,0);
    add(1,5,0,0,0,0, 16'h9876,4,0,16'h1230,0,0,0);
    add(0,0,1,0,0,0, 16'h0000,0,0,16'h1230,0,0,0);
    // tens digit > 5 rejected
    add(1,1,0,0,0,0, 16'h0001,1,0,16'h1230,0,0,0);
    add(1,7,0,0,0,0, 16'h0017,2,0,16'h1230,0,0,0);
    add(1,5,0,0,0,0, 16'h0175,3,0,16'h1230,0,0,0);
    add(0,0,0,1,0,0, 16'h0175,3,0,16'h1230,0,1,0);
    add(0,0,0,0,0,0, 16'h0175,3,0,16'h1230,0,0,0);
    add(0,0,1,0,0,0, 16'h0000,0,0,16'h1230,0,0,0);
    // all-zero buffer rejected
    add(1,0,0,0,0,0, 16'h0000,1,0,16'h1230,0,0,0);
    add(1,0,0,0,0,0, 16'h0000,2,0,16'h1230,0,0,0);
    add(0,0,0,1,0,0, 16'h0000,2,0,16'h1230,0,1,0);
    add(0,0,0,0,0,0, 16'h0000,2,0,16'h1230,0,0,0);
    add(0,0,1,0,0,0, 16'h0000,0,0,16'h1230,0,0,0);
    // clear beats key; start in IDLE ignored
    add(1,4,0,0,0,0, 16'h0004,1,0,16'h1230,0,0,0);
    add(1,4,1,0,0,0, 16'h0000,0,0,16'h1230,0,0,0);
    add(0,0,0,1,0,0, 16'h0000,0,0,16'h1230,0,0,0);
    // ack beats clear in LOAD; clear in RUN cancels
    add(1,2,0,0,0,0, 16'h0002,1,0,16'h1230,0,0,0);
    add(1,5,0,0,0,0, 16'h0025,2,0,16'h1230,0,0,0);
    add(0,0,0,1,0,0, 16'h0025,2,1,16'h0025,0,0,0);
    add(0,0,1,0,1,0, 16'h0000,0,0,16'h0025,1,0,0);
    add(1,7,0,1,0,0, 16'h0000,0,0,16'h0025,1,0,0);
    add(0,0,1,0,0,0, 16'h0000,0,0,16'h0025,0,0,1);
    add(0,0,0,0,0,0, 16'h0000,0,0,16'h0025,0,0,0);
    // clear in LOAD returns to ENTRY with buffer intact
    add(1,4,0,0,0,0, 16'h0004,1,0,16'h0025,0,0,0);
    add(1,5,0,0,0,0, 16'h0045,2,0,16'h0025,0,0,0);
    add(0,0,0,1,0,0, 16'h0045,2,1,16'h0045,0,0,0);
    add(0,0,1,0,0,0, 16'h0045,2,0,16'h0045,0,0,0);
    add(1,6,0,0,0,0, 16'h0456,3,0,16'h0045,0,0,0);
    add(0,0,1,0,0,0, 16'h0000,0,0,16'h0045,0,0,0);
    // clear with timer_done in RUN still cancels
    add(1,1,0,0,0,0, 16'h0001,1,0,16'h0045,0,0,0);
    add(0,0,0,1,0,0, 16'h0001,1,1,16'h0001,0,0,0);
    add(0,0,0,0,1,0, 16'h0000,0,0,16'h0001,1,0,0);
    add(0,0,1,0,0,1, 16'h0000,0,0,16'h0001,0,0,1);
    add(0,0,0,0,0,0, 16'h0000,0,0,16'h0001,0,0,0);

    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", obs(), 39'd0);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].kv, tbl[i].kc, tbl[i].clr, tbl[i].st,
            tbl[i].ack, tbl[i].done);
      chk($sformatf("vec%0d", i), obs(),
          {tbl[i].ev, tbl[i].ec, tbl[i].req, tbl[i].lv,
           tbl[i].mux, tbl[i].er, tbl[i].can});
    end

    // random run against the model from a fresh reset
    drive(0,0,0,0,0,0);
    rst_n = 1'b0;
    #2 rst_n = 1'b1;
    m_reset();
    for (int i = 0; i < 3000; i++) begin
      mdrive("rand", 1'($urandom_range(0,1)), 4'($urandom_range(0,15)),
             $urandom_range(0,19) == 0, $urandom_range(0,7) == 0,
             $urandom_range(0,3) == 0, $urandom_range(0,9) == 0);
    end

    // asynchronous reset while in LOAD
    drive(0,0,0,0,0,0);
    rst_n = 1'b0;
    #2 rst_n = 1'b1;
    m_reset();
    mdrive("pre_rst_key", 1, 4'd3, 0, 0, 0, 0);
    mdrive("pre_rst_start", 0, 4'd0, 0, 1, 0, 0);
    #3 rst_n = 1'b0;
    #1 chk("async_reset", obs(), 39'd0);
    #2 rst_n = 1'b1;
    m_reset();
    mdrive("post_rst_ack", 0, 4'd0, 0, 0, 1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/timer_input_ctrl.md
# timer_input_ctrl

Sequencer for the microwave timer input path. Collects BCD digits from the keypad encoder into an MM:SS entry buffer, validates and hands the value to the countdown timer over a request/acknowledge handshake, and drives the select line of the 2:1 display mux. When `mux_sel` is 0 the display shows the entry buffer; when it is 1 the display shows the live timer count.

## Interface
- `DIGITS`, default 4: number of BCD digits in the buffer. Must be ≥2. Digit 0 is seconds-units and digit 1 is seconds-tens.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `key_valid`  in  1  one-cycle strobe; `key_code` is valid this cycle.
- `key_code`  in  4  BCD digit; codes 10–15 are ignored.
- `clear`  in  1  one-cycle pulse; clears the entry, or aborts a running timer.
- `start`  in  1  one-cycle pulse; request to start cooking.
- `load_ack`  in  1  timer accepted `load_value`.
- `timer_done`  in  1  one-cycle pulse from the timer when the count reaches zero.
- `entry_value`  out  4*DIGITS  BCD entry buffer, most significant digit in the upper nibble.
- `digit_count`  out  $clog2(DIGITS+1)  number of digits entered.
- `load_req`  out  1  held high until `load_ack`.
- `load_value`  out  4*DIGITS  value offered to the timer; stable while `load_req` is high.
- `mux_sel`  out  1  display mux select (0 = entry, 1 = timer).
- `timer_cancel`  out  1  one-cycle abort pulse to the timer.
- `err`  out  1  one-cycle pulse on a rejected start.

## Operation
States: IDLE, ENTRY, LOAD, RUN. Reset puts the block in IDLE. All outputs reset to 0.

- **IDLE**
  - Buffer is 0.
  - A valid `key_valid` shifts the digit in: buffer ← {buffer[4*DIGITS-5:0], key_code}. `digit_count` ← 1. Go to ENTRY.
  - `start` with the macro off: ignored.
- **ENTRY**
  - A valid key shifts the digit in and increments `digit_count`.
  - When `digit_count`==DIGITS, further keys are dropped: no shift, count saturates.
  - `clear`: buffer ← 0, count ← 0, go to IDLE.
  - `start`:
    - If buffer is all zero or digit 1 > 5: pulse `err`, stay in ENTRY.
    - Otherwise: `load_value` ← buffer, `load_req` ← 1, go to LOAD.
- **LOAD**
  - Keys and `start` are ignored.
  - `load_ack` high: `load_req` ← 0, buffer ← 0, count ← 0, `mux_sel` ← 1, go to RUN.
  - `clear` in LOAD: `load_req` ← 0, go to ENTRY with the buffer intact. `timer_cancel` is not pulsed.
- **RUN**
  - Keys and `start` are ignored.
  - `timer_done`: `mux_sel` ← 0, go to IDLE.
  - `clear`: pulse `timer_cancel`, `mux_sel` ← 0, go to IDLE.
- **Priority within a cycle:** clear > start > key_valid.
  - `clear` together with a key in ENTRY: the key is dropped.
  - `clear` together with `timer_done` in RUN: go to IDLE and still pulse `timer_cancel`.
  - `clear` together with `load_ack` in LOAD: `load_ack` wins and the block goes to RUN; the clear is discarded.
- A reset in any state returns to IDLE within the same cycle (asynchronous). Any pending `load_req` is dropped without a cancel pulse.

## Timing
- All outputs are registered. Every response appears on the edge after the stimulus is sampled.
- `start` → `load_req`=1: 1 cycle.
- `load_ack` → `load_req`=0 and `mux_sel`=1: 1 cycle.
- `load_ack` is sampled only while `load_req`=1. `load_req` may stay high indefinitely; the block has no timeout.
- `err` and `timer_cancel` are exactly 1 cycle wide.
- `timer_done` → `mux_sel`=0: 1 cycle.
- `entry_value` updates 1 cycle after `key_valid`.
- Back-to-back `key_valid` on consecutive cycles: every digit is captured.

## Configuration
- `TIMER_INPUT_QUICKSTART_EN` defined:
  - `start` in IDLE loads a quick-start value: BCD 30 seconds, i.e. digit 1 = 3, digit 0 = 0, all other digits 0.
  - This sets `load_value` and `load_req` and goes to LOAD, with the same 1-cycle latency as a normal start.
  - Clearing from that LOAD goes to ENTRY with the buffer at 0 and `digit_count` 0.
- Undefined: `start` in IDLE is ignored and `err` is not pulsed.

## Test plan
- **Entry, load and completion:** reset; keys 1,2,3,0; `start`.
  - `entry_value`=0x1230 and `load_req`=1 on the next cycle.
  - `load_ack` → `mux_sel`=1.
  - `timer_done` → `mux_sel`=0 and state IDLE.
- **Saturation:** keys 9,8,7,6,5 → `entry_value`=0x9876, `digit_count`=4, fifth key dropped.
- **Invalid start:**
  - Keys 1,7,5 then `start` → `err` pulses 1 cycle, `load_req` stays 0.
  - An all-zero buffer (keys 0,0) then `start` → `err` pulses 1 cycle.
- **Same-cycle conflicts:**
  - `clear` and `key_valid`(4) in the same cycle in ENTRY → buffer 0, state IDLE.
  - `clear` and `load_ack` in the same cycle in LOAD → RUN, `mux_sel`=1.
- **Abort and reset:**
  - `clear` in RUN → `timer_cancel` pulses 1 cycle, `mux_sel`=0.
  - `rst_n` low mid-LOAD → `load_req`=0 immediately, all outputs 0.
- **Quick start** (macro on): `start` in IDLE → `load_value`=0x0030 and `load_req`=1 after 1 cycle. With the macro off, the same stimulus gives no response.
